// File: rtl/ddr2_pkg.sv
// Shared DDR2 init definitions: command encodings, mode-register bit positions,
// bank codes and the init sequencer state enum.
package ddr2_pkg;

  localparam logic [3:0] CMD_NOP = 4'b0111;
  localparam logic [3:0] CMD_PRE = 4'b0010;
  localparam logic [3:0] CMD_REF = 4'b0001;
  localparam logic [3:0] CMD_LM  = 4'b0000;

  localparam int A_PRE_ALL = 10;
  localparam int A_DLL_RST = 8;
  localparam int A_OCD_HI  = 9;
  localparam int A_OCD_LO  = 7;
  localparam int A_DLL_DIS = 0;

  localparam logic [1:0] BA_MR   = 2'd0;
  localparam logic [1:0] BA_EMR1 = 2'd1;
  localparam logic [1:0] BA_EMR2 = 2'd2;
  localparam logic [1:0] BA_EMR3 = 2'd3;

  // Each command state means "command issued, its spacing is running".
  typedef enum logic [3:0] {
    S_PWR_WAIT,
    S_CKE_WAIT,
    S_PRE1,
    S_EMR2,
    S_EMR3,
    S_EMR1_DLL,
    S_MR_DLLRST,
    S_PRE2,
    S_REF1,
    S_REF2,
    S_MR_RUN,
    S_OCD_DEF,
    S_OCD_EXIT,
    S_DLL_WAIT,
    S_DONE
  } init_state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ddr2_init_timer.sv
// Loadable down-counter with zero flag; times every wait of the init sequencer.
module ddr2_init_timer #(
  parameter int W = 8
) (
  input  logic         ck,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  localparam logic [W-1:0] ONE_C  = W'(1'b1);
  localparam logic [W-1:0] ZERO_C = W'(1'b0);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: load wins, otherwise count down and stick at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != ZERO_C) begin
      cnt_d = cnt_q - ONE_C;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= ZERO_C;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == ZERO_C);

endmodule

// File: rtl/ddr2_init_seq.sv
// DDR2 power-up / warm re-init sequencer driving CKE, command, BA and address.
// Define DDR2_INIT_OCD_EN to add the OCD default/exit EMR1 writes after MR_RUN.
module ddr2_init_seq
  import ddr2_pkg::*;
#(
  parameter int                   BA_BITS   = 3,
  parameter int                   ADDR_BITS = 14,
  parameter int                   T_PWR_CYC = 60000,
  parameter int                   T_CKE_CYC = 100,
  parameter int                   T_RP_CYC  = 3,
  parameter int                   T_MRD_CYC = 2,
  parameter int                   T_RFC_CYC = 26,
  parameter int                   T_DLL_CYC = 200,
  parameter logic [ADDR_BITS-1:0] MR_VAL    = 14'h0A62,
  parameter logic [ADDR_BITS-1:0] EMR1_VAL  = 14'h0000,
  parameter logic [ADDR_BITS-1:0] EMR2_VAL  = 14'h0000,
  parameter logic [ADDR_BITS-1:0] EMR3_VAL  = 14'h0000
) (
  input  logic                 ck,
  input  logic                 rst_n,
  input  logic                 reinit_req,
  output logic                 init_cke,
  output logic [3:0]           init_cmd,
  output logic [BA_BITS-1:0]   init_ba,
  output logic [ADDR_BITS-1:0] init_addr,
  output logic                 init_busy,
  output logic                 init_done
);

  if (T_PWR_CYC < 1 || T_CKE_CYC < 1 || T_RP_CYC < 1 || T_MRD_CYC < 1 ||
      T_RFC_CYC < 1 || T_DLL_CYC < 1 || BA_BITS < 2 || ADDR_BITS < 11) begin : g_bad_param
    $fatal(1, "ddr2_init_seq: every timing parameter must be >= 1");
  end

  localparam int T_MAX = max_int(max_int(max_int(T_PWR_CYC, T_CKE_CYC), max_int(T_RP_CYC, T_MRD_CYC)),
                                 max_int(T_RFC_CYC, T_DLL_CYC));
  localparam int CNT_W = $clog2(T_MAX + 1);

  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1'b1);
  localparam logic [CNT_W-1:0] ZERO_C  = CNT_W'(1'b0);
  localparam logic [CNT_W-1:0] PWR_END = CNT_W'(T_PWR_CYC - 1);
  localparam logic [CNT_W-1:0] DLL_MIN = CNT_W'(T_DLL_CYC);
  localparam logic [CNT_W-1:0] LD_CKE  = CNT_W'(T_CKE_CYC - 1);
  localparam logic [CNT_W-1:0] LD_RP   = CNT_W'(T_RP_CYC - 1);
  localparam logic [CNT_W-1:0] LD_MRD  = CNT_W'(T_MRD_CYC - 1);
  localparam logic [CNT_W-1:0] LD_RFC  = CNT_W'(T_RFC_CYC - 1);

  localparam logic [ADDR_BITS-1:0] ONE_A    = ADDR_BITS'(1'b1);
  localparam logic [ADDR_BITS-1:0] OCD_MASK = ((ONE_A << (A_OCD_HI - A_OCD_LO + 1)) - ONE_A) << A_OCD_LO;
  localparam logic [ADDR_BITS-1:0] ADDR_PRE = ONE_A << A_PRE_ALL;
  localparam logic [ADDR_BITS-1:0] ADDR_E1D = EMR1_VAL & ~OCD_MASK & ~(ONE_A << A_DLL_DIS);
  localparam logic [ADDR_BITS-1:0] ADDR_MRR = MR_VAL | (ONE_A << A_DLL_RST);
  localparam logic [ADDR_BITS-1:0] ADDR_MRN = MR_VAL & ~(ONE_A << A_DLL_RST);
  localparam logic [ADDR_BITS-1:0] ADDR_OCD = EMR1_VAL | OCD_MASK;
  localparam logic [ADDR_BITS-1:0] ADDR_OCX = EMR1_VAL & ~OCD_MASK;

  init_state_e          state_q, state_d;
  logic                 cke_q, cke_d;
  logic [3:0]           cmd_q, cmd_d;
  logic [BA_BITS-1:0]   ba_q, ba_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [CNT_W-1:0]     up_cnt_q, up_cnt_d;
  logic                 tmr_load;
  logic [CNT_W-1:0]     tmr_val;
  logic                 tmr_zero;
  logic                 dll_run;
  logic                 dll_ok;

  ddr2_init_timer #(.W(CNT_W)) u_timer (
    .ck       (ck),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  // up_cnt times the power-up wait, then is reused as the DLL-lock age.
  assign dll_run = state_q inside {S_MR_DLLRST, S_PRE2, S_REF1, S_REF2, S_MR_RUN,
                                   S_OCD_DEF, S_OCD_EXIT, S_DLL_WAIT};
  assign dll_ok  = (up_cnt_q >= DLL_MIN);

  // Next state, then the command and timer load for the state being entered.
  always_comb begin
    state_d  = state_q;
    cke_d    = cke_q;
    cmd_d    = CMD_NOP;
    ba_d     = ba_q;
    addr_d   = addr_q;
    busy_d   = busy_q;
    done_d   = done_q;
    tmr_load = 1'b0;
    tmr_val  = ZERO_C;
    if (state_q == S_PWR_WAIT || (dll_run && !dll_ok)) begin
      up_cnt_d = up_cnt_q + ONE_C;
    end else begin
      up_cnt_d = up_cnt_q;
    end

    case (state_q)
      S_PWR_WAIT:  state_d = (up_cnt_q == PWR_END) ? S_CKE_WAIT : state_q;
      S_CKE_WAIT:  state_d = tmr_zero ? S_PRE1 : state_q;
      S_PRE1:      state_d = tmr_zero ? S_EMR2 : state_q;
      S_EMR2:      state_d = tmr_zero ? S_EMR3 : state_q;
      S_EMR3:      state_d = tmr_zero ? S_EMR1_DLL : state_q;
      S_EMR1_DLL:  state_d = tmr_zero ? S_MR_DLLRST : state_q;
      S_MR_DLLRST: state_d = tmr_zero ? S_PRE2 : state_q;
      S_PRE2:      state_d = tmr_zero ? S_REF1 : state_q;
      S_REF1:      state_d = tmr_zero ? S_REF2 : state_q;
      S_REF2:      state_d = tmr_zero ? S_MR_RUN : state_q;
`ifdef DDR2_INIT_OCD_EN
      S_MR_RUN:    state_d = tmr_zero ? S_OCD_DEF : state_q;
`else
      S_MR_RUN:    state_d = !tmr_zero ? state_q : (dll_ok ? S_DONE : S_DLL_WAIT);
`endif
      S_OCD_DEF:   state_d = tmr_zero ? S_OCD_EXIT : state_q;
      S_OCD_EXIT:  state_d = !tmr_zero ? state_q : (dll_ok ? S_DONE : S_DLL_WAIT);
      S_DLL_WAIT:  state_d = dll_ok ? S_DONE : state_q;
      S_DONE:      state_d = reinit_req ? S_PRE1 : state_q;
      default:     state_d = S_PWR_WAIT;
    endcase

    if (state_d != state_q) begin
      case (state_d)
        S_CKE_WAIT: begin
          cke_d = 1'b1;  tmr_load = 1'b1;  tmr_val = LD_CKE;  up_cnt_d = ZERO_C;
        end
        S_PRE1: begin
          cmd_d = CMD_PRE;  ba_d = {BA_BITS{1'b0}};  addr_d = ADDR_PRE;
          tmr_load = 1'b1;  tmr_val = LD_RP;
          busy_d = 1'b1;  done_d = 1'b0;  up_cnt_d = ZERO_C;
        end
        S_EMR2: begin
          cmd_d = CMD_LM;  ba_d = BA_BITS'(BA_EMR2);  addr_d = EMR2_VAL;
          tmr_load = 1'b1;  tmr_val = LD_MRD;
        end
        S_EMR3: begin
          cmd_d = CMD_LM;  ba_d = BA_BITS'(BA_EMR3);  addr_d = EMR3_VAL;
          tmr_load = 1'b1;  tmr_val = LD_MRD;
        end
        S_EMR1_DLL: begin
          cmd_d = CMD_LM;  ba_d = BA_BITS'(BA_EMR1);  addr_d = ADDR_E1D;
          tmr_load = 1'b1;  tmr_val = LD_MRD;
        end
        S_MR_DLLRST: begin
          cmd_d = CMD_LM;  ba_d = BA_BITS'(BA_MR);  addr_d = ADDR_MRR;
          tmr_load = 1'b1;  tmr_val = LD_MRD;  up_cnt_d = ZERO_C;
        end
        S_PRE2: begin
          cmd_d = CMD_PRE;  ba_d = {BA_BITS{1'b0}};  addr_d = ADDR_PRE;
          tmr_load = 1'b1;  tmr_val = LD_RP;
        end
        S_REF1, S_REF2: begin
          cmd_d = CMD_REF;  tmr_load = 1'b1;  tmr_val = LD_RFC;
        end
        S_MR_RUN: begin
          cmd_d = CMD_LM;  ba_d = BA_BITS'(BA_MR);  addr_d = ADDR_MRN;
          tmr_load = 1'b1;  tmr_val = LD_MRD;
        end
        S_OCD_DEF: begin
          cmd_d = CMD_LM;  ba_d = BA_BITS'(BA_EMR1);  addr_d = ADDR_OCD;
          tmr_load = 1'b1;  tmr_val = LD_MRD;
        end
        S_OCD_EXIT: begin
          cmd_d = CMD_LM;  ba_d = BA_BITS'(BA_EMR1);  addr_d = ADDR_OCX;
          tmr_load = 1'b1;  tmr_val = LD_MRD;
        end
        S_DONE: begin
          busy_d = 1'b0;  done_d = 1'b1;
        end
        default: begin
          cmd_d = CMD_NOP;
        end
      endcase
    end else begin
      cmd_d = CMD_NOP;
    end
  end

  // State and registered outputs.
  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_PWR_WAIT;
      cke_q    <= 1'b0;
      cmd_q    <= CMD_NOP;
      ba_q     <= {BA_BITS{1'b0}};
      addr_q   <= {ADDR_BITS{1'b0}};
      busy_q   <= 1'b1;
      done_q   <= 1'b0;
      up_cnt_q <= ZERO_C;
    end else begin
      state_q  <= state_d;
      cke_q    <= cke_d;
      cmd_q    <= cmd_d;
      ba_q     <= ba_d;
      addr_q   <= addr_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      up_cnt_q <= up_cnt_d;
    end
  end

  assign init_cke  = cke_q;
  assign init_cmd  = cmd_q;
  assign init_ba   = ba_q;
  assign init_addr = addr_q;
  assign init_busy = busy_q;
  assign init_done = done_q;

endmodule

// File: tb/tb_ddr2_init_seq.sv
// Scoreboard bench for ddr2_init_seq: cold start, warm re-init, mid-sequence reset,
// reinit_req ignored while busy, and a short-DLL instance where spacing gates done.
module tb_ddr2_init_seq;

  localparam int TP = 20, TC = 4, TRP = 3, TMRD = 2, TRFC = 8, TDLL = 30, TDLL_F = 5;

  logic        ck = 1'b0;
  logic        rst_n;
  logic        reinit_req;
  logic        init_cke, f_cke;
  logic [3:0]  init_cmd, f_cmd;
  logic [2:0]  init_ba, f_ba;
  logic [13:0] init_addr, f_addr;
  logic        init_busy, f_busy;
  logic        init_done, f_done;

  always #5 ck = ~ck;

  ddr2_init_seq #(.T_PWR_CYC(TP), .T_CKE_CYC(TC), .T_RP_CYC(TRP), .T_MRD_CYC(TMRD),
                  .T_RFC_CYC(TRFC), .T_DLL_CYC(TDLL)) dut (
    .ck(ck), .rst_n(rst_n), .reinit_req(reinit_req), .init_cke(init_cke), .init_cmd(init_cmd),
    .init_ba(init_ba), .init_addr(init_addr), .init_busy(init_busy), .init_done(init_done));

  ddr2_init_seq #(.T_PWR_CYC(TP), .T_CKE_CYC(TC), .T_RP_CYC(TRP), .T_MRD_CYC(TMRD),
                  .T_RFC_CYC(TRFC), .T_DLL_CYC(TDLL_F)) dut_fast (
    .ck(ck), .rst_n(rst_n), .reinit_req(1'b0), .init_cke(f_cke), .init_cmd(f_cmd),
    .init_ba(f_ba), .init_addr(f_addr), .init_busy(f_busy), .init_done(f_done));

  typedef struct { int cyc; logic [3:0] cmd; logic [2:0] ba; logic [13:0] addr; } cmd_ev_t;
  typedef struct { int cyc; logic val; } lvl_ev_t;

  cmd_ev_t exp_cmd_q[$];
  lvl_ev_t exp_cke_q[$];
  lvl_ev_t exp_done_q[$];
  lvl_ev_t exp_fdone_q[$];

  int checks = 0;
  int errors = 0;
  int cyc;
  logic prev_cke, prev_done, prev_fdone;
  cmd_ev_t mon_cev;
  lvl_ev_t mon_lev;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp_v, cyc);
    end
  endtask

  function automatic void add_cmd(input int c, input logic [3:0] cmd, input logic [2:0] ba,
                                  input logic [13:0] addr);
    cmd_ev_t e;
    e.cyc = c;  e.cmd = cmd;  e.ba = ba;  e.addr = addr;
    exp_cmd_q.push_back(e);
  endfunction

  function automatic void add_lvl(input int which, input int c, input logic v);
    lvl_ev_t e;
    e.cyc = c;  e.val = v;
    if (which == 0) exp_cke_q.push_back(e);
    else if (which == 1) exp_done_q.push_back(e);
    else exp_fdone_q.push_back(e);
  endfunction

  // Command list starting with the first precharge at cycle p; returns done cycles.
  task automatic push_seq(input int p, output int done_main, output int done_fast);
    int c, dll;
    c = p;
    add_cmd(c, 4'b0010, 3'd0, 14'h0400);  c += TRP;
    add_cmd(c, 4'b0000, 3'd2, 14'h0000);  c += TMRD;
    add_cmd(c, 4'b0000, 3'd3, 14'h0000);  c += TMRD;
    add_cmd(c, 4'b0000, 3'd1, 14'h0000);  c += TMRD;
    add_cmd(c, 4'b0000, 3'd0, 14'h0B62);  dll = c;  c += TMRD;
    add_cmd(c, 4'b0010, 3'd0, 14'h0400);  c += TRP;
    add_cmd(c, 4'b0001, 3'd0, 14'h0400);  c += TRFC;
    add_cmd(c, 4'b0001, 3'd0, 14'h0400);  c += TRFC;
    add_cmd(c, 4'b0000, 3'd0, 14'h0A62);  c += TMRD;
`ifdef DDR2_INIT_OCD_EN
    add_cmd(c, 4'b0000, 3'd1, 14'h0380);  c += TMRD;
    add_cmd(c, 4'b0000, 3'd1, 14'h0000);  c += TMRD;
`endif
    done_main = (c > dll + TDLL + 1) ? c : dll + TDLL + 1;
    done_fast = (c > dll + TDLL_F + 1) ? c : dll + TDLL_F + 1;
  endtask

  task automatic flush_all();
    exp_cmd_q.delete();
    exp_cke_q.delete();
    exp_done_q.delete();
    exp_fdone_q.delete();
  endtask

  task automatic release_cold();
    int dm, df;
    @(posedge ck);
    #2;
    add_lvl(0, TP, 1'b1);
    push_seq(TP + TC, dm, df);
    add_lvl(1, dm, 1'b1);
    add_lvl(2, df, 1'b1);
    rst_n = 1'b1;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (init_done !== 1'b1 && n < 300) begin
      @(negedge ck);
      n++;
    end
    check(tag, {31'b0, init_done}, 32'd1);
  endtask

  // Cycle index: 0 between reset release and the first rising edge.
  always @(posedge ck or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else cyc <= cyc + 1;
  end

  // Scoreboard monitor, sampled on the falling edge.
  always @(negedge ck) begin
    if (!rst_n) begin
      prev_cke   <= 1'b0;
      prev_done  <= 1'b0;
      prev_fdone <= 1'b0;
    end else begin
      if (init_cmd !== 4'b0111) begin
        if (exp_cmd_q.size() == 0) begin
          check("cmd_unexpected", {28'b0, init_cmd}, 32'h7);
        end else begin
          mon_cev = exp_cmd_q.pop_front();
          check("cmd_cycle", cyc, mon_cev.cyc);
          check("cmd_code", {28'b0, init_cmd}, {28'b0, mon_cev.cmd});
          check("cmd_ba", {29'b0, init_ba}, {29'b0, mon_cev.ba});
          check("cmd_addr", {18'b0, init_addr}, {18'b0, mon_cev.addr});
        end
      end
      if (init_cke !== prev_cke) begin
        if (exp_cke_q.size() == 0) begin
          check("cke_unexpected", {31'b0, init_cke}, {31'b0, prev_cke});
        end else begin
          mon_lev = exp_cke_q.pop_front();
          check("cke_cycle", cyc, mon_lev.cyc);
          check("cke_val", {31'b0, init_cke}, {31'b0, mon_lev.val});
        end
      end
      if (init_done !== prev_done) begin
        if (exp_done_q.size() == 0) begin
          check("done_unexpected", {31'b0, init_done}, {31'b0, prev_done});
        end else begin
          mon_lev = exp_done_q.pop_front();
          check("done_cycle", cyc, mon_lev.cyc);
          check("done_val", {31'b0, init_done}, {31'b0, mon_lev.val});
          check("busy_at_done", {31'b0, init_busy}, {31'b0, !mon_lev.val});
        end
      end
      if (f_done !== prev_fdone) begin
        if (exp_fdone_q.size() == 0) begin
          check("fast_done_unexpected", {31'b0, f_done}, {31'b0, prev_fdone});
        end else begin
          mon_lev = exp_fdone_q.pop_front();
          check("fast_done_cycle", cyc, mon_lev.cyc);
          check("fast_busy", {31'b0, f_busy}, {31'b0, !mon_lev.val});
        end
      end
      prev_cke   <= init_cke;
      prev_done  <= init_done;
      prev_fdone <= f_done;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int r, dm, df;
    rst_n = 1'b0;
    reinit_req = 1'b1;
    repeat (3) @(negedge ck);
    check("rst_cke", {31'b0, init_cke}, 32'd0);
    check("rst_cmd", {28'b0, init_cmd}, 32'h7);
    check("rst_ba", {29'b0, init_ba}, 32'd0);
    check("rst_addr", {18'b0, init_addr}, 32'd0);
    check("rst_busy", {31'b0, init_busy}, 32'd1);
    check("rst_done", {31'b0, init_done}, 32'd0);

    // Cold start with reinit_req held high until just before done.
    release_cold();
    while (cyc < 60) @(negedge ck);
    reinit_req = 1'b0;
    wait_done("cold_done");

    // Warm re-init pulse ten cycles after done.
    repeat (10) @(negedge ck);
    r = cyc;
    add_lvl(1, r + 1, 1'b0);
    push_seq(r + 1, dm, df);
    add_lvl(1, dm, 1'b1);
    reinit_req = 1'b1;
    @(negedge ck);
    reinit_req = 1'b0;
    check("reinit_cke", {31'b0, init_cke}, 32'd1);
    wait_done("reinit_done");

    // Fresh cold start, then reset asserted inside the first refresh wait.
    @(negedge ck);
    rst_n = 1'b0;
    flush_all();
    repeat (3) @(negedge ck);
    release_cold();
    while (cyc < 40) @(negedge ck);
    check("pre_rst_addr", {18'b0, init_addr}, 32'h0400);
    #2;
    rst_n = 1'b0;
    flush_all();
    #1;
    check("async_cke", {31'b0, init_cke}, 32'd0);
    check("async_cmd", {28'b0, init_cmd}, 32'h7);
    check("async_addr", {18'b0, init_addr}, 32'd0);
    check("async_busy", {31'b0, init_busy}, 32'd1);
    check("async_done", {31'b0, init_done}, 32'd0);
    repeat (3) @(negedge ck);
    release_cold();
    wait_done("restart_done");

    repeat (3) @(negedge ck);
    check("cmd_left", exp_cmd_q.size(), 32'd0);
    check("cke_left", exp_cke_q.size(), 32'd0);
    check("done_left", exp_done_q.size(), 32'd0);
    check("fast_left", exp_fdone_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
